// File: rtl/assignment5_pkg.sv
// Shared constants and types for the assignment5 delay line.
// Parameter defaults live here so every module agrees on them.
package assignment5_pkg;

    localparam int unsigned DEFAULT_SIZE  = 10;
    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // The output register sits behind the size-deep chain, so one extra register.
    function automatic int unsigned reg_count(input int unsigned depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/assignment5_stage.sv
// One delay-line register: async active-low clear, loads d when load is high.
module assignment5_stage
    import assignment5_pkg::*;
#(
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/assignment5_delay_line.sv
// Enable-gated delay line: size+1 registers in series, out driven by the last one.
// Define ASSIGNMENT5_VALID_EN to add a valid flag chain and the out_valid port.
module assignment5_delay_line
    import assignment5_pkg::*;
#(
    parameter int unsigned size  = DEFAULT_SIZE,
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [width-1:0] out,
    input  logic [width-1:0] in,
    input  logic             enable
`ifdef ASSIGNMENT5_VALID_EN
    ,
    output logic             out_valid
`endif
);

    localparam int unsigned NREG = reg_count(size);

    // data_q[0] is s[0], data_q[size-1] is s[size-1], data_q[size] drives out.
    logic [width-1:0] data_q [NREG];

    genvar g;
    for (g = 0; g < NREG; g++) begin : g_data
        logic [width-1:0] d;
        if (g == 0) begin : g_head
            assign d = in;
        end else begin : g_body
            assign d = data_q[g-1];
        end
        assignment5_stage #(
            .width (width)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (enable),
            .d     (d),
            .q     (data_q[g])
        );
    end

    assign out = data_q[NREG-1];

`ifdef ASSIGNMENT5_VALID_EN
    // Every enabled edge injects a valid word, so flags mark post-reset data.
    logic [0:0] flag_q [NREG];

    for (g = 0; g < NREG; g++) begin : g_flag
        logic [0:0] d;
        if (g == 0) begin : g_head
            assign d = 1'b1;
        end else begin : g_body
            assign d = flag_q[g-1];
        end
        assignment5_stage #(
            .width (1)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (enable),
            .d     (d),
            .q     (flag_q[g])
        );
    end

    assign out_valid = flag_q[NREG-1][0];
`endif

endmodule

// File: tb/tb_assignment5_delay_line.sv
// Directed, table-driven bench for assignment5_delay_line at size=10, width=8.
module tb_assignment5_delay_line;

    localparam int SIZE  = 10;
    localparam int WIDTH = 8;

    typedef struct {
        logic             en;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_out;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out;
`ifdef ASSIGNMENT5_VALID_EN
    logic             out_valid;
`endif

    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assignment5_delay_line #(
        .size  (SIZE),
        .width (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .out       (out),
        .in        (din),
        .enable    (enable)
`ifdef ASSIGNMENT5_VALID_EN
        ,
        .out_valid (out_valid)
`endif
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: out=%0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input logic e, input logic [WIDTH-1:0] d,
                                 input logic [WIDTH-1:0] x);
        vec_t v;
        v.en      = e;
        v.din     = d;
        v.exp_out = x;
        vecs.push_back(v);
    endfunction

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic step(input logic e, input logic [WIDTH-1:0] d);
        @(negedge clk);
        enable = e;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].din);
            check($sformatf("%s[%0d]", name, i), out, vecs[i].exp_out);
        end
        vecs.delete();
    endtask

    // Reset asserted and released between clock edges; out must clear without a clock.
    task automatic do_reset(input string name);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        #2;
        check(name, out, '0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        enable = 1'b0;
        din    = '0;
        #1;
        rst_n = 1'b0;
        #10;
        check("power_on_reset", out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and hold: disabled for 20 cycles, random input ignored.
        for (int i = 0; i < 20; i++) push(1'b0, WIDTH'($urandom_range(1, 255)), 8'd0);
        run_table("hold");

        // Fill and latency.
        push(1'b1, 8'd1, 8'd0);
        push(1'b1, 8'd2, 8'd0);
        push(1'b1, 8'd3, 8'd0);
        for (int i = 0; i < 7; i++) push(1'b1, 8'd0, 8'd0);
        push(1'b1, 8'd0, 8'd1);
        push(1'b1, 8'd0, 8'd2);
        push(1'b1, 8'd0, 8'd3);
        for (int i = 0; i < 20; i++) push(1'b1, 8'd0, 8'd0);
        run_table("fill");

        // Stall with out=1, then resume.
        do_reset("reset_before_stall");
        push(1'b1, 8'd1, 8'd0);
        push(1'b1, 8'd2, 8'd0);
        push(1'b1, 8'd3, 8'd0);
        for (int i = 0; i < 7; i++) push(1'b1, 8'd0, 8'd0);
        push(1'b1, 8'd0, 8'd1);
        for (int i = 0; i < 20; i++) push(1'b0, 8'hAA, 8'd1);
        push(1'b1, 8'd0, 8'd2);
        push(1'b1, 8'd0, 8'd3);
        for (int i = 0; i < 12; i++) push(1'b1, 8'd0, 8'd0);
        run_table("stall");

        // Input ignored while disabled: 4 must never surface.
        do_reset("reset_before_ignore");
        push(1'b0, 8'd4, 8'd0);
        for (int i = 0; i < 20; i++) push(1'b1, 8'd0, 8'd0);
        run_table("ignore");

        // Async reset mid-stream discards 5..14.
        do_reset("reset_before_flush");
        for (int i = 0; i < 10; i++) push(1'b1, WIDTH'(5 + i), 8'd0);
        push(1'b1, 8'd0, 8'd5);
        push(1'b1, 8'd0, 8'd6);
        run_table("preload");
        do_reset("reset_mid_stream");
        push(1'b1, 8'd20, 8'd0);
        for (int i = 0; i < 9; i++) push(1'b1, 8'd0, 8'd0);
        push(1'b1, 8'd0, 8'd20);
        for (int i = 0; i < 3; i++) push(1'b1, 8'd0, 8'd0);
        run_table("after_flush");

`ifdef ASSIGNMENT5_VALID_EN
        do_reset("reset_before_valid");
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_after_reset: out_valid=%0b expected 0", out_valid);
        end
        step(1'b1, 8'h77);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 8'd0);
            n_cmp++;
            if (out_valid !== (k == 10)) begin
                n_err++;
                $display("FAIL valid_edge%0d: out_valid=%0b expected %0b", k, out_valid, k == 10);
            end
        end
        check("valid_word", out, 8'h77);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_async_clear: out_valid=%0b expected 0", out_valid);
        end
        #1;
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
